// File: rtl/float_to_fixed_convert.sv
// rtl/float_to_fixed_convert.sv - IEEE-754 single to W-bit two's-complement fixed-point converter
//
// Converts a single-precision float into a Q(W-1-FRAC).FRAC two's-complement word
// over a fixed five-state start/done sequence (IDLE, CAPT, ALIGN, SIGN, DONE).
//
// Ports:
//   CLK           system clock, rising edge
//   RST_FF        synchronous active-low reset
//   Begin_FSM_FF  start request, sampled only in IDLE
//   FLOAT         single-precision operand, registered on the start edge
//   ACK_FF        conversion done, high throughout DONE
//   RESULT        fixed-point result, held until the next conversion's SIGN edge
//   OVF           result saturated (out of range or Inf)
//   INV           operand was NaN
module float_to_fixed_convert #(
    parameter int W    = 32,
    parameter int FRAC = 26
) (
    input  logic         CLK,
    input  logic         RST_FF,
    input  logic         Begin_FSM_FF,
    input  logic [31:0]  FLOAT,
    output logic         ACK_FF,
    output logic [W-1:0] RESULT,
    output logic         OVF,
    output logic         INV
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CAPT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_SIGN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Operand classes decided in CAPT; only K_NORM goes through the shifter.
    localparam logic [2:0] K_NORM = 3'd0;  // ordinary in-range value
    localparam logic [2:0] K_ZERO = 3'd1;  // zero, denormal or underflow
    localparam logic [2:0] K_NAN  = 3'd2;
    localparam logic [2:0] K_SAT  = 3'd3;  // Inf or magnitude out of range
    localparam logic [2:0] K_MIN  = 3'd4;  // exactly -2^(W-1-FRAC): representable

    localparam int WIDE    = W + 24;
    // Smallest biased exponent whose magnitude no longer fits the integer part.
    localparam int OVF_EXP = 127 + W - 1 - FRAC;

    localparam logic [11:0]        OVF_EXP_V = 12'(OVF_EXP);
    localparam logic signed [11:0] SH_BIAS   = 12'(FRAC - 150);
    localparam logic [W-1:0]       POS_SAT   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]       NEG_SAT   = {1'b1, {(W-1){1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [31:0]       float_q, float_d;
    logic              sign_q, sign_d;
    logic [2:0]        kind_q, kind_d;
    logic signed [11:0] sh_q, sh_d;
    logic [23:0]       mant_q, mant_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [W-1:0]      result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              inv_q, inv_d;

    logic [11:0]       exp_w;
    logic [22:0]       frac_f;
    logic [WIDE-1:0]   ext;

    assign exp_w  = {4'b0000, float_q[30:23]};
    assign frac_f = float_q[22:0];
    assign ext    = {{W{1'b0}}, mant_q};

    always_comb begin
        state_d  = state_q;
        float_d  = float_q;
        sign_d   = sign_q;
        kind_d   = kind_q;
        sh_d     = sh_q;
        mant_d   = mant_q;
        mag_d    = mag_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;

        case (state_q)
            S_IDLE: begin
                if (Begin_FSM_FF) begin
                    float_d = FLOAT;
                    state_d = S_CAPT;
                end
            end

            S_CAPT: begin
                sign_d = float_q[31];
                mant_d = {1'b1, frac_f};
                sh_d   = $signed(exp_w) + SH_BIAS;
                // Overflow is judged from the exponent alone, so the shifter
                // never has to produce more than W-1 magnitude bits.
                if (exp_w == 12'd0) begin
                    kind_d = K_ZERO;
                end else if (exp_w == 12'd255) begin
                    kind_d = (frac_f != 23'd0) ? K_NAN : K_SAT;
                end else if (exp_w >= OVF_EXP_V) begin
                    if (float_q[31] && exp_w == OVF_EXP_V && frac_f == 23'd0)
                        kind_d = K_MIN;
                    else
                        kind_d = K_SAT;
                end else if (sh_d <= -12'sd24) begin
                    kind_d = K_ZERO;
                end else begin
                    kind_d = K_NORM;
                end
                state_d = S_ALIGN;
            end

            S_ALIGN: begin
                // For K_NORM the left amount is at most W-25 and the right
                // amount at most 23, so the narrowed shift counts are exact.
                if (kind_q != K_NORM)
                    mag_d = '0;
                else if (sh_q >= 12'sd0)
                    mag_d = W'(ext << 7'(sh_q));
                else
                    mag_d = W'(ext >> 5'(-sh_q));
                state_d = S_SIGN;
            end

            S_SIGN: begin
                ovf_d = 1'b0;
                inv_d = 1'b0;
                case (kind_q)
                    K_NORM: result_d = sign_q ? ((~mag_q) + W'(1)) : mag_q;
                    K_NAN: begin
                        result_d = '0;
                        inv_d    = 1'b1;
                    end
                    K_SAT: begin
                        result_d = sign_q ? NEG_SAT : POS_SAT;
                        ovf_d    = 1'b1;
                    end
                    K_MIN:   result_d = NEG_SAT;
                    default: result_d = '0;
                endcase
                state_d = S_DONE;
            end

            S_DONE: begin
                if (!Begin_FSM_FF)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_FF) begin
            state_q  <= S_IDLE;
            float_q  <= '0;
            sign_q   <= 1'b0;
            kind_q   <= K_ZERO;
            sh_q     <= '0;
            mant_q   <= '0;
            mag_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            float_q  <= float_d;
            sign_q   <= sign_d;
            kind_q   <= kind_d;
            sh_q     <= sh_d;
            mant_q   <= mant_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign ACK_FF = (state_q == S_DONE);
    assign RESULT = result_q;
    assign OVF    = ovf_q;
    assign INV    = inv_q;

endmodule

// File: tb/tb_float_to_fixed_convert.sv
// tb/tb_float_to_fixed_convert.sv - directed self-checking bench for float_to_fixed_convert
module tb_float_to_fixed_convert;

    logic        CLK = 1'b0;
    logic        RST_FF;
    logic        Begin_FSM_FF;
    logic [31:0] FLOAT;
    logic        ACK_FF;
    logic [31:0] RESULT;
    logic        OVF;
    logic        INV;

    int checks   = 0;
    int failures = 0;

    float_to_fixed_convert #(.W(32), .FRAC(26)) dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FF (Begin_FSM_FF),
        .FLOAT        (FLOAT),
        .ACK_FF       (ACK_FF),
        .RESULT       (RESULT),
        .OVF          (OVF),
        .INV          (INV)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
    task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] exp_r,
                           input logic exp_ovf, input logic exp_inv);
        FLOAT = f;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        FLOAT = ~f;
        @(negedge CLK);
        @(negedge CLK);
        chk({tag, ".ack_early"}, {31'd0, ACK_FF}, 32'd0);
        @(negedge CLK);
        chk({tag, ".ack"}, {31'd0, ACK_FF}, 32'd1);
        chk({tag, ".result"}, RESULT, exp_r);
        chk({tag, ".ovf"}, {31'd0, OVF}, {31'd0, exp_ovf});
        chk({tag, ".inv"}, {31'd0, INV}, {31'd0, exp_inv});
        @(negedge CLK);
        chk({tag, ".ack_idle"}, {31'd0, ACK_FF}, 32'd0);
        chk({tag, ".hold"}, RESULT, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_FF = 1'b0;
        Begin_FSM_FF = 1'b0;
        FLOAT = 32'h0;
        repeat (3) @(negedge CLK);
        chk("reset.ack", {31'd0, ACK_FF}, 32'd0);
        chk("reset.result", RESULT, 32'd0);
        chk("reset.ovf", {31'd0, OVF}, 32'd0);
        chk("reset.inv", {31'd0, INV}, 32'd0);
        RST_FF = 1'b1;
        @(negedge CLK);

        convert("pos1",     32'h3F800000, 32'h04000000, 1'b0, 1'b0);
        convert("neg1",     32'hBF800000, 32'hFC000000, 1'b0, 1'b0);
        convert("half",     32'h3F000000, 32'h02000000, 1'b0, 1'b0);
        convert("onept5",   32'h3FC00000, 32'h06000000, 1'b0, 1'b0);
        convert("maxfit",   32'h41FFFFFF, 32'h7FFFFF80, 1'b0, 1'b0);
        convert("pos32",    32'h42000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        convert("neg32",    32'hC2000000, 32'h80000000, 1'b0, 1'b0);
        convert("neg32p",   32'hC2000001, 32'h80000000, 1'b1, 1'b0);
        convert("neginf",   32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        convert("posinf",   32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        convert("p2m25",    32'h33000000, 32'h00000002, 1'b0, 1'b0);
        convert("p2m26",    32'h32800000, 32'h00000001, 1'b0, 1'b0);
        convert("p2m27",    32'h32000000, 32'h00000000, 1'b0, 1'b0);
        convert("n2m27",    32'hB2000000, 32'h00000000, 1'b0, 1'b0);
        convert("ntrunc",   32'hB2C00000, 32'hFFFFFFFF, 1'b0, 1'b0);
        convert("denorm",   32'h00000001, 32'h00000000, 1'b0, 1'b0);
        convert("nan",      32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
        convert("negzero",  32'h80000000, 32'h00000000, 1'b0, 1'b0);

        // Begin held high: DONE persists until Begin drops.
        FLOAT = 32'h3FC00000;
        Begin_FSM_FF = 1'b1;
        repeat (4) @(negedge CLK);
        chk("hold.ack", {31'd0, ACK_FF}, 32'd1);
        chk("hold.result", RESULT, 32'h06000000);
        repeat (3) @(negedge CLK);
        chk("hold.ack_still", {31'd0, ACK_FF}, 32'd1);
        chk("hold.result_still", RESULT, 32'h06000000);
        Begin_FSM_FF = 1'b0;
        @(negedge CLK);
        chk("hold.release_ack", {31'd0, ACK_FF}, 32'd0);
        chk("hold.release_result", RESULT, 32'h06000000);

        // A Begin pulse while in ALIGN must not disturb the conversion.
        FLOAT = 32'h40000000;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        @(negedge CLK);
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        chk("pulse.ack_early", {31'd0, ACK_FF}, 32'd0);
        @(negedge CLK);
        chk("pulse.ack", {31'd0, ACK_FF}, 32'd1);
        chk("pulse.result", RESULT, 32'h08000000);
        @(negedge CLK);
        chk("pulse.idle1", {31'd0, ACK_FF}, 32'd0);
        @(negedge CLK);
        chk("pulse.idle2", {31'd0, ACK_FF}, 32'd0);

        // Reset asserted during ALIGN aborts without an ACK.
        FLOAT = 32'hC0400000;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        @(negedge CLK);
        RST_FF = 1'b0;
        @(negedge CLK);
        chk("abort.ack", {31'd0, ACK_FF}, 32'd0);
        chk("abort.result", RESULT, 32'd0);
        chk("abort.ovf", {31'd0, OVF}, 32'd0);
        chk("abort.inv", {31'd0, INV}, 32'd0);
        RST_FF = 1'b1;
        @(negedge CLK);
        chk("abort.no_done", {31'd0, ACK_FF}, 32'd0);
        @(negedge CLK);
        chk("abort.still_idle", {31'd0, ACK_FF}, 32'd0);
        convert("neg3", 32'hC0400000, 32'hF4000000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
